// File: rtl/serial_comparator_if.sv
// Operand, control and result signals of the serial magnitude comparator.
interface serial_comparator_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             clr_cnt;
    logic             busy;
    logic             done;
    logic             eq;
    logic             lt;
    logic             gt;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output start, a, b, signed_mode, clr_cnt,
        input  busy, done, eq, lt, gt, match_cnt
    );

    modport slave (
        input  start, a, b, signed_mode, clr_cnt,
        output busy, done, eq, lt, gt, match_cnt
    );
endinterface

// File: rtl/serial_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle with early exit,
// optional two's-complement mode and a saturating count of equal results.
module serial_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_comparator_if.slave bus
);
    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_a, r_b, w_a_nx, w_b_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic             r_busy, r_done, r_eq, r_lt, r_gt;
    logic             w_busy_nx, w_done_nx, w_eq_nx, w_lt_nx, w_gt_nx;
    logic             w_inc;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [WIDTH-1:0] w_flip;
    logic [DIGIT-1:0] w_dig_a, w_dig_b;

    // Operands are shifted left each step, so the active digit is always the top slice.
    assign w_dig_a = r_a[WIDTH-1 -: DIGIT];
    assign w_dig_b = r_b[WIDTH-1 -: DIGIT];
    assign w_flip  = bus.signed_mode ? MSB_MASK : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_idx   <= w_idx_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_eq    <= w_eq_nx;
            r_lt    <= w_lt_nx;
            r_gt    <= w_gt_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_idx_nx   = r_idx;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_eq_nx    = r_eq;
        w_lt_nx    = r_lt;
        w_gt_nx    = r_gt;
        w_inc      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    // Offset-binary conversion turns a signed compare into an unsigned one.
                    w_a_nx     = bus.a ^ w_flip;
                    w_b_nx     = bus.b ^ w_flip;
                    w_idx_nx   = IDX_W'(NDIG - 1);
                    w_eq_nx    = 1'b0;
                    w_lt_nx    = 1'b0;
                    w_gt_nx    = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_dig_a != w_dig_b) begin
                    w_lt_nx    = (w_dig_a < w_dig_b);
                    w_gt_nx    = (w_dig_a > w_dig_b);
                    w_done_nx  = 1'b1;
                    w_state_nx = ST_DONE;
                end else if (r_idx == '0) begin
                    w_eq_nx    = 1'b1;
                    w_inc      = 1'b1;
                    w_done_nx  = 1'b1;
                    w_state_nx = ST_DONE;
                end else begin
                    w_a_nx    = r_a << DIGIT;
                    w_b_nx    = r_b << DIGIT;
                    w_idx_nx  = r_idx - IDX_W'(1);
                    w_busy_nx = 1'b1;
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase

        // Clear wins over a simultaneous increment.
        w_cnt_nx = r_cnt;
        if (bus.clr_cnt) begin
            w_cnt_nx = '0;
        end else if (w_inc && (r_cnt != CNT_MAX)) begin
            w_cnt_nx = r_cnt + CNT_W'(1);
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.eq        = r_eq;
    assign bus.lt        = r_lt;
    assign bus.gt        = r_gt;
    assign bus.match_cnt = r_cnt;
endmodule

// File: tb/tb_serial_comparator.sv
// Directed-vector bench for serial_comparator (WIDTH=16, DIGIT=4, CNT_W=8).
module tb_serial_comparator;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_comparator_if #(.WIDTH(16), .CNT_W(8)) u_if ();

    serial_comparator #(.WIDTH(16), .DIGIT(4), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one compare; returns edges from accept to done (0 = timed out).
    // disturb: zero A/B and hold start during RUN; clr_edge: pulse clr_cnt into that edge.
    task automatic do_cmp(input logic [15:0] a, input logic [15:0] b, input logic sm,
                          input logic disturb, input int clr_edge, output int k);
        @(negedge clk);
        u_if.a           = a;
        u_if.b           = b;
        u_if.signed_mode = sm;
        u_if.start       = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = disturb;
        if (disturb) begin
            u_if.a = '0;
            u_if.b = '0;
        end
        u_if.clr_cnt = (clr_edge == 1);
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            u_if.start   = 1'b0;
            u_if.clr_cnt = (i + 1 == clr_edge);
            if (u_if.done) begin
                k = i;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int k;

    initial begin
        errors           = 0;
        checks           = 0;
        rst_n            = 1'b0;
        u_if.start       = 1'b0;
        u_if.a           = '0;
        u_if.b           = '0;
        u_if.signed_mode = 1'b0;
        u_if.clr_cnt     = 1'b0;
        #23;
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_flags", {29'd0, u_if.eq, u_if.lt, u_if.gt}, 32'd0);
        check("rst_cnt", 32'(u_if.match_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. equal operands, including busy during RUN
        @(negedge clk);
        u_if.a = 16'h1234; u_if.b = 16'h1234; u_if.signed_mode = 1'b0; u_if.start = 1'b1;
        @(posedge clk); #1; u_if.start = 1'b0;
        check("t1_busy_e0", 32'(u_if.busy), 32'd1);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        check("t1_busy_e3", {30'd0, u_if.busy, u_if.done}, 32'b10);
        @(posedge clk); #1;
        check("t1_done_e4", {30'd0, u_if.busy, u_if.done}, 32'b01);
        check("t1_flags", {29'd0, u_if.eq, u_if.lt, u_if.gt}, 32'b100);
        check("t1_cnt", 32'(u_if.match_cnt), 32'd1);
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(u_if.done), 32'd0);

        // 2. early exit
        do_cmp(16'h5000, 16'h4FFF, 1'b0, 1'b0, 0, k);
        check("t2_lat", 32'(k), 32'd1);
        check("t2_flags", {29'd0, u_if.eq, u_if.lt, u_if.gt}, 32'b001);
        check("t2_cnt", 32'(u_if.match_cnt), 32'd1);

        // 3. signed vs unsigned
        do_cmp(16'hFFFF, 16'h0001, 1'b1, 1'b0, 0, k);
        check("t3s_lat", 32'(k), 32'd1);
        check("t3s_flags", {29'd0, u_if.eq, u_if.lt, u_if.gt}, 32'b010);
        do_cmp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, k);
        check("t3u_flags", {29'd0, u_if.eq, u_if.lt, u_if.gt}, 32'b001);

        // 4. late difference with operands zeroed and start pulsed during RUN
        do_cmp(16'hABC3, 16'hABC7, 1'b0, 1'b1, 0, k);
        check("t4_lat", 32'(k), 32'd4);
        check("t4_flags", {29'd0, u_if.eq, u_if.lt, u_if.gt}, 32'b010);
        check("t4_idle", {30'd0, u_if.busy, u_if.done}, 32'b00);
        check("t4_cnt", 32'(u_if.match_cnt), 32'd1);

        // 5. saturation, then clear colliding with an eq completion
        for (int n = 0; n < 260; n++) begin
            do_cmp(16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 0, k);
        end
        check("t5_sat", 32'(u_if.match_cnt), 32'hFF);
        do_cmp(16'h8001, 16'h8001, 1'b1, 1'b0, 4, k);
        check("t5_clr_lat", 32'(k), 32'd4);
        check("t5_clr_eq", {29'd0, u_if.eq, u_if.lt, u_if.gt}, 32'b100);
        check("t5_clr_cnt", 32'(u_if.match_cnt), 32'd0);
        do_cmp(16'h7777, 16'h7777, 1'b0, 1'b0, 0, k);
        check("t5_recount", 32'(u_if.match_cnt), 32'd1);

        // 6. reset after edge 2 of a compare
        @(negedge clk);
        u_if.a = 16'h2222; u_if.b = 16'h2222; u_if.start = 1'b1;
        @(posedge clk); #1; u_if.start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", {29'd0, u_if.busy, u_if.done, u_if.eq}, 32'd0);
        check("t6_rst_cmp", {30'd0, u_if.lt, u_if.gt}, 32'd0);
        check("t6_rst_cnt", 32'(u_if.match_cnt), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check("t6_no_done", 32'(u_if.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_cmp(16'h0010, 16'h0020, 1'b0, 1'b0, 0, k);
        check("t6_after_lat", 32'(k), 32'd3);
        check("t6_after_flags", {29'd0, u_if.eq, u_if.lt, u_if.gt}, 32'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
